// File: rtl/seed_loader_pkg.sv
// Shared types and constants for the Toeplitz seed loader.
// Consumed by seed_loader and rom_lat_pipe.
package seed_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DRAIN = 2'b10,
        HOLD  = 2'b11
    } state_e;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_SEED_WORDS = 224;
    localparam int DEF_SEED_SLOTS = 1;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_ROM_LAT    = 1;
    localparam int DEF_AUTO_LOAD  = 0;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rom_lat_pipe.sv
// Valid delay line that tags ROM read data arriving LAT cycles after the read enable.
module rom_lat_pipe
    import seed_loader_pkg::*;
#(
    parameter int LAT = DEF_ROM_LAT
) (
    input  logic clk_in,
    input  logic rst,
    input  logic in_vld,
    output logic out_vld
);

    logic [LAT-1:0] vld_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | LAT'(in_vld);
        end
    end

    assign out_vld = vld_q[LAT-1];

endmodule

// File: rtl/seed_loader.sv
// Fetches a multi-word Toeplitz seed from ROM, assembles it MSB-first and offers it via valid/ready.
// Optional SEED_LOADER_CHK_EN adds seed_chk, the XOR of all words of the current seed.
//   state | meaning
//   IDLE  | waiting for start (or leaves at once with AUTO_LOAD)
//   FETCH | issuing one ROM read per cycle for the current slot
//   DRAIN | reads done, waiting for the last in-flight word
//   HOLD  | seed complete, waiting for consumer handshake
module seed_loader
    import seed_loader_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int SEED_WORDS = DEF_SEED_WORDS,
    parameter int SEED_SLOTS = DEF_SEED_SLOTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ROM_LAT    = DEF_ROM_LAT,
    parameter int AUTO_LOAD  = DEF_AUTO_LOAD,
    localparam int SEED_W    = WORD_W * SEED_WORDS,
    localparam int SLOT_W    = (SEED_SLOTS > 1) ? clog2(SEED_SLOTS) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              seed_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEED_W-1:0] seed,
    output logic              seed_valid,
    output logic [SLOT_W-1:0] slot,
`ifdef SEED_LOADER_CHK_EN
    output logic [WORD_W-1:0] seed_chk,
`endif
    output logic              busy
);

    localparam int CNT_W = (SEED_WORDS > 1) ? clog2(SEED_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(SEED_WORDS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SEED_SLOTS - 1);

    generate
        if (SEED_SLOTS * SEED_WORDS > 2 ** ADDR_W) begin : g_addr_chk
            $error("seed_loader: SEED_SLOTS*SEED_WORDS exceeds the ROM address space");
        end
        if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_chk
            $error("seed_loader: ROM_LAT must be in 1..4");
        end
    endgenerate

    state_e            state_q;
    logic [CNT_W-1:0]  issue_q;
    logic [CNT_W-1:0]  cap_q;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              rom_en_q;
    logic              seed_valid_q;
    logic              busy_q;
    logic [SEED_W-1:0] seed_q;
    logic [SEED_W-1:0] seed_d;
    logic              cap_vld;
`ifdef SEED_LOADER_CHK_EN
    logic [WORD_W-1:0] chk_q;
`endif

    function automatic logic [ADDR_W-1:0] base_of(input logic [SLOT_W-1:0] s);
        return ADDR_W'(int'(s) * SEED_WORDS);
    endfunction

    rom_lat_pipe #(
        .LAT (ROM_LAT)
    ) u_lat (
        .clk_in  (clk_in),
        .rst     (rst),
        .in_vld  (rom_en_q),
        .out_vld (cap_vld)
    );

    always_comb begin
        seed_d = (seed_q << WORD_W) | SEED_W'(rom_data);
        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_q      <= '0;
            cap_q        <= '0;
            slot_q       <= '0;
            rom_addr_q   <= '0;
            rom_en_q     <= 1'b0;
            seed_q       <= '0;
            seed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SEED_LOADER_CHK_EN
            chk_q        <= '0;
`endif
        end else begin
            // Captures run independently of state; the last one always lands in DRAIN.
            if (cap_vld) begin
                seed_q <= seed_d;
                cap_q  <= cap_q + CNT_W'(1);
`ifdef SEED_LOADER_CHK_EN
                chk_q  <= chk_q ^ rom_data;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (start || AUTO_LOAD != 0) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= base_of(slot_q);
                        issue_q    <= '0;
                        cap_q      <= '0;
                        seed_q     <= '0;
`ifdef SEED_LOADER_CHK_EN
                        chk_q      <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (issue_q == LAST_IDX) begin
                        state_q  <= DRAIN;
                        rom_en_q <= 1'b0;
                    end else begin
                        issue_q    <= issue_q + CNT_W'(1);
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (cap_vld && cap_q == LAST_IDX) begin
                        state_q      <= HOLD;
                        seed_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (seed_ready) begin
                        seed_valid_q <= 1'b0;
                        slot_q       <= slot_d;
                        if (AUTO_LOAD != 0) begin
                            state_q    <= FETCH;
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= base_of(slot_d);
                            issue_q    <= '0;
                            cap_q      <= '0;
                            seed_q     <= '0;
`ifdef SEED_LOADER_CHK_EN
                            chk_q      <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign seed       = seed_q;
    assign seed_valid = seed_valid_q;
    assign slot       = slot_q;
    assign busy       = busy_q;
`ifdef SEED_LOADER_CHK_EN
    assign seed_chk   = chk_q;
`endif

endmodule

// File: tb/tb_seed_loader.sv
// Bench for seed_loader: two instances (ROM_LAT=3 manual, ROM_LAT=1 auto-reload) checked each cycle
// against a timeline model of the load sequence, plus a few literal pins.
module tb_seed_loader;

    localparam int WW = 8;
    localparam int SW = 4;
    localparam int NS = 3;
    localparam int AW = 4;

    function automatic int lat_of(input int u);
        return (u == 0) ? 3 : 1;
    endfunction

    function automatic bit auto_of(input int u);
        return (u == 0) ? 1'b0 : 1'b1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          start      [2];
    logic          seed_ready [2];
    logic [WW-1:0] rom_data   [2];
    logic          rom_en     [2];
    logic [AW-1:0] rom_addr   [2];
    logic [31:0]   seed       [2];
    logic          seed_valid [2];
    logic [1:0]    slot       [2];
    logic          busy       [2];
`ifdef SEED_LOADER_CHK_EN
    logic [WW-1:0] seed_chk   [2];
`endif

    seed_loader #(
        .WORD_W(WW), .SEED_WORDS(SW), .SEED_SLOTS(NS), .ADDR_W(AW), .ROM_LAT(3), .AUTO_LOAD(0)
    ) u0 (
        .clk_in(clk), .rst(rst[0]), .start(start[0]), .rom_data(rom_data[0]),
        .seed_ready(seed_ready[0]), .rom_en(rom_en[0]), .rom_addr(rom_addr[0]),
        .seed(seed[0]), .seed_valid(seed_valid[0]), .slot(slot[0]),
`ifdef SEED_LOADER_CHK_EN
        .seed_chk(seed_chk[0]),
`endif
        .busy(busy[0])
    );

    seed_loader #(
        .WORD_W(WW), .SEED_WORDS(SW), .SEED_SLOTS(NS), .ADDR_W(AW), .ROM_LAT(1), .AUTO_LOAD(1)
    ) u1 (
        .clk_in(clk), .rst(rst[1]), .start(start[1]), .rom_data(rom_data[1]),
        .seed_ready(seed_ready[1]), .rom_en(rom_en[1]), .rom_addr(rom_addr[1]),
        .seed(seed[1]), .seed_valid(seed_valid[1]), .slot(slot[1]),
`ifdef SEED_LOADER_CHK_EN
        .seed_chk(seed_chk[1]),
`endif
        .busy(busy[1])
    );

    // ROM with per-instance read latency
    logic [WW-1:0] rom_mem [16];
    logic [WW-1:0] rpipe   [2][4];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            rpipe[u][0] <= rom_mem[rom_addr[u]];
            for (int i = 1; i < 4; i++) rpipe[u][i] <= rpipe[u][i-1];
        end
    end
    assign rom_data[0] = rpipe[0][2];
    assign rom_data[1] = rpipe[1][0];

    // Timeline model: m_k = cycles since the current load began (first read cycle is k=0)
    int cyc = 0;
    bit m_on [2];
    int m_k [2];
    int m_slot [2];
    bit m_first [2];
    bit m_rstd [2];
    bit m_live [2];
    bit m_justx [2];
    int m_xfers [2];
    int m_loads [2];
    int m_st [2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_rstd[u]  = 1'b0;
            m_justx[u] = 1'b0;
            if (rst[u]) begin
                m_on[u] = 1'b0; m_slot[u] = 0; m_first[u] = 1'b1; m_rstd[u] = 1'b1;
                m_live[u] = 1'b1; m_xfers[u] = 0; m_loads[u] = 0;
            end else if (!m_on[u]) begin
                if (start[u] || (auto_of(u) && m_first[u])) begin
                    m_on[u] = 1'b1; m_k[u] = 0; m_st[u] = cyc; m_loads[u]++;
                end
                m_first[u] = 1'b0;
            end else if (m_k[u] >= SW + lat_of(u) && seed_ready[u]) begin
                m_slot[u] = (m_slot[u] + 1) % NS;
                m_justx[u] = 1'b1;
                m_xfers[u]++;
                if (auto_of(u)) begin
                    m_k[u] = 0; m_st[u] = cyc; m_loads[u]++;
                end else begin
                    m_on[u] = 1'b0;
                end
            end else begin
                m_k[u]++;
            end
        end
        cyc++;
    end

    function automatic logic [31:0] exp_seed(input int s);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < SW; j++) r = (r << 8) | 32'(rom_mem[s*SW + j]);
        return r;
    endfunction

    function automatic logic [31:0] exp_chk(input int s);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < SW; j++) r = r ^ 32'(rom_mem[s*SW + j]);
        return r;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] cyc=%0d: got %0h want %0h", nm, u, cyc, act, exp);
        end
    endtask

    bit lit_lat_done = 1'b0;
    bit lit_auto_done = 1'b0;
    bit lit_wrap_done = 1'b0;
    bit lit_u1_done = 1'b0;

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (m_live[u]) begin
                bit e_en;
                bit e_v;
                e_en = m_on[u] && m_k[u] < SW;
                e_v  = m_on[u] && m_k[u] >= SW + lat_of(u);
                chk("busy", u, 32'(busy[u]), 32'(m_on[u]));
                chk("rom_en", u, 32'(rom_en[u]), 32'(e_en));
                chk("seed_valid", u, 32'(seed_valid[u]), 32'(e_v));
                chk("slot", u, 32'(slot[u]), m_slot[u]);
                if (e_en) chk("rom_addr", u, 32'(rom_addr[u]), m_slot[u]*SW + m_k[u]);
                if (e_v) begin
                    chk("seed", u, seed[u], exp_seed(m_slot[u]));
`ifdef SEED_LOADER_CHK_EN
                    chk("seed_chk", u, 32'(seed_chk[u]), exp_chk(m_slot[u]));
`endif
                end
                if (m_rstd[u]) begin
                    chk("rst_addr", u, 32'(rom_addr[u]), 0);
                    chk("rst_seed", u, seed[u], 0);
`ifdef SEED_LOADER_CHK_EN
                    chk("rst_chk", u, 32'(seed_chk[u]), 0);
`endif
                end
            end
        end
        if (!lit_lat_done && m_live[0] && m_loads[0] == 1 && seed_valid[0] === 1'b1) begin
            lit_lat_done = 1'b1;
            chk("lit_latency", 0, cyc - m_st[0], 8);
            chk("lit_seed", 0, seed[0], 32'h11223344);
`ifdef SEED_LOADER_CHK_EN
            chk("lit_chk", 0, 32'(seed_chk[0]), 32'h44);
`endif
        end
        if (!lit_u1_done && m_live[1] && m_loads[1] == 1 && seed_valid[1] === 1'b1) begin
            lit_u1_done = 1'b1;
            chk("lit_u1_latency", 1, cyc - m_st[1], 6);
            chk("lit_u1_seed", 1, seed[1], 32'h11223344);
        end
        if (!lit_auto_done && m_justx[1] && m_xfers[1] == 1) begin
            lit_auto_done = 1'b1;
            chk("lit_auto_en", 1, 32'(rom_en[1]), 1);
            chk("lit_auto_addr", 1, 32'(rom_addr[1]), 4);
            chk("lit_auto_valid", 1, 32'(seed_valid[1]), 0);
        end
        if (!lit_wrap_done && m_justx[0] && m_xfers[0] == 3) begin
            lit_wrap_done = 1'b1;
            chk("lit_wrap_slot", 0, 32'(slot[0]), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid0(input int budget);
        int n;
        n = 0;
        while (seed_valid[0] !== 1'b1) begin
            if (n >= budget) begin
                $display("FAIL wait_valid[u0]: seed_valid not seen within %0d cycles", budget);
                $fatal(1, "timeout");
            end
            step();
            n++;
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; seed_ready[u] = 1'b0;
        end
        for (int a = 0; a < 16; a++) rom_mem[a] = 8'($urandom);
        rom_mem[0] = 8'h11; rom_mem[1] = 8'h22; rom_mem[2] = 8'h33; rom_mem[3] = 8'h44;
        repeat (3) step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        seed_ready[1] = 1'b1;

        // four back-to-back loads: slots 0,1,2 then wrap to 0
        seed_ready[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            start[0] = 1'b1; step(); start[0] = 1'b0;
            wait_valid0(40);
            step();
        end

        // hold with consumer stalled, start pulses must be ignored
        seed_ready[0] = 1'b0;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        wait_valid0(40);
        for (int n = 0; n < 20; n++) begin
            start[0] = 1'($urandom_range(0, 1));
            step();
        end
        start[0] = 1'b0; seed_ready[0] = 1'b1;
        repeat (2) step();

        // reset mid-fetch, then restart right away with reads still in flight
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (2) step();
        rst[0] = 1'b1; step(); rst[0] = 1'b0;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        wait_valid0(40);
        step();

        for (int n = 0; n < 3000; n++) begin
            for (int u = 0; u < 2; u++) begin
                start[u]      = ($urandom_range(0, 5) == 0);
                seed_ready[u] = ($urandom_range(0, 2) == 0);
                rst[u]        = ($urandom_range(0, 249) == 0);
            end
            step();
        end
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; start[u] = 1'b0; seed_ready[u] = 1'b1;
        end
        repeat (20) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
